qpsk_symbol_mapper: RTL and testbench

Maps the 2-bit QPSK symbols leaving the 32-bit-to-2-bit converter/repeater chain onto sc16 I/Q constellation points for the DAC/pulse-shaping path. Each input beat carries one dibit in bits [1:0]. Each output beat carries one complex sample. The block supports Gray or natural bit-to-phase mapping, optional differential phase encoding, and a runtime amplitude. It sits between the symbol repeater output and the framework's outgoing sample stream, inside the same axis_data_clk domain.

---
 rtl/qpsk_symbol_mapper.sv | 159 +++++++++++++++
 tb/tb_qpsk_symbol_mapper.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_symbol_mapper.sv
// qpsk_symbol_mapper: maps 2-bit QPSK dibits onto sc16 I/Q constellation points.
// Two-stage pipeline (phase/amplitude, then I/Q words) with AXI-Stream style
// handshakes on both sides. Optional Gray mapping, differential phase encoding
// and a runtime amplitude.
module qpsk_symbol_mapper #(
   parameter logic [15:0] DEFAULT_AMP  = 16'd23170,
   parameter bit          DEFAULT_GRAY = 1'b1,
   parameter bit          DEFAULT_DIFF = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] in_tdata,
   input  logic        in_tlast,
   input  logic        in_tvalid,
   output logic        in_tready,
   output logic [31:0] out_tdata,
   output logic        out_tlast,
   output logic        out_tvalid,
   input  logic        out_tready,
   input  logic [15:0] cfg_amp,
   input  logic        cfg_gray,
   input  logic        cfg_diff,
   input  logic        cfg_amp_stb,
   input  logic        phase_clear,
   output logic [31:0] sym_count
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned AMP_W  = 16;
   localparam int unsigned PH_W   = 2;
   localparam int unsigned CNT_W  = 32;
   localparam logic [AMP_W-1:0] AMP_MAX = 16'h7FFF;

   // Configuration registers
   logic [AMP_W-1:0]  r_amp;
   logic              r_gray;
   logic              r_diff;

   // Differential phase accumulator
   logic [PH_W-1:0]   r_acc;

   // Stage 1: phase, amplitude, tlast
   logic              r_s1_valid;
   logic [PH_W-1:0]   r_s1_phase;
   logic [AMP_W-1:0]  r_s1_amp;
   logic              r_s1_last;

   // Stage 2: output beat
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_last;
   logic [CNT_W-1:0]  r_sym_count;

   logic              w_adv;
   logic              w_accept;
   logic              w_xfer;
   logic [PH_W-1:0]   w_dibit;
   logic [PH_W-1:0]   w_p;
   logic [PH_W-1:0]   w_acc_base;
   logic [PH_W-1:0]   w_acc_sum;
   logic [PH_W-1:0]   w_phase;
   logic [AMP_W-1:0]  w_neg_amp;
   logic [AMP_W-1:0]  w_i;
   logic [AMP_W-1:0]  w_q;
   logic              w_unused;

   // Whole pipeline advances when the output slot is free or being drained
   assign w_adv     = out_tready | ~r_out_valid;
   assign w_accept  = in_tvalid & w_adv;
   assign w_xfer    = r_out_valid & out_tready;
   assign in_tready = w_adv;

   // Only the low dibit of the input word carries information
   assign w_unused  = ^in_tdata[DATA_W-1:PH_W];
   assign w_dibit   = in_tdata[PH_W-1:0];

   // Gray: 00->0, 01->1, 11->2, 10->3; natural: p = dibit
   assign w_p        = r_gray ? {w_dibit[1], w_dibit[1] ^ w_dibit[0]} : w_dibit;
   // A coincident phase_clear takes effect before the accumulation
   assign w_acc_base = phase_clear ? '0 : r_acc;
   assign w_acc_sum  = PH_W'(w_acc_base + w_p);
   assign w_phase    = r_diff ? w_acc_sum : w_p;

   // Constellation point from stage-1 phase: I negative for phases 1,2; Q for 2,3
   assign w_neg_amp = AMP_W'(~r_s1_amp + AMP_W'(1));
   assign w_i       = (r_s1_phase[1] ^ r_s1_phase[0]) ? w_neg_amp : r_s1_amp;
   assign w_q       = r_s1_phase[1] ? w_neg_amp : r_s1_amp;

   // Config registers load on strobe; bit 15 saturates so -A stays representable
   always_ff @(posedge clk) begin
      if (reset) begin
         r_amp  <= DEFAULT_AMP;
         r_gray <= DEFAULT_GRAY;
         r_diff <= DEFAULT_DIFF;
      end else if (cfg_amp_stb) begin
         r_amp  <= cfg_amp[AMP_W-1] ? AMP_MAX : cfg_amp;
         r_gray <= cfg_gray;
         r_diff <= cfg_diff;
      end
   end

   // Accumulator updates on accepted differential beats, or clears alone
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc <= '0;
      end else if (w_accept && r_diff) begin
         r_acc <= w_acc_sum;
      end else if (phase_clear) begin
         r_acc <= '0;
      end
   end

   // Stage 1 captures the emitted phase and the amplitude in force at accept
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_phase <= '0;
         r_s1_amp   <= '0;
         r_s1_last  <= 1'b0;
      end else if (w_adv) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_phase <= w_phase;
            r_s1_amp   <= r_amp;
            r_s1_last  <= in_tlast;
         end
      end
   end

   // Stage 2 registers the I/Q word; bubbles only clear the valid
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_data <= {w_i, w_q};
            r_out_last <= r_s1_last;
         end
      end
   end

   // Count transferred output beats, wrapping naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sym_count <= '0;
      end else if (w_xfer) begin
         r_sym_count <= CNT_W'(r_sym_count + CNT_W'(1));
      end
   end

   assign out_tvalid = r_out_valid;
   assign out_tdata  = r_out_data;
   assign out_tlast  = r_out_last;
   assign sym_count  = r_sym_count;

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// tb_qpsk_symbol_mapper: directed and backpressure checks for qpsk_symbol_mapper.
module tb_qpsk_symbol_mapper;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_tdata = '0;
   logic        in_tlast = 1'b0;
   logic        in_tvalid = 1'b0;
   logic        in_tready;
   logic [31:0] out_tdata;
   logic        out_tlast;
   logic        out_tvalid;
   logic        out_tready = 1'b1;
   logic [15:0] cfg_amp = '0;
   logic        cfg_gray = 1'b0;
   logic        cfg_diff = 1'b0;
   logic        cfg_amp_stb = 1'b0;
   logic        phase_clear = 1'b0;
   logic [31:0] sym_count;

   int          n_vec = 0;
   int          n_err = 0;
   int          n_xfer = 0;
   logic [32:0] q_obs[$];
   logic [32:0] q_exp[$];
   bit          bp_en = 1'b0;
   bit          rdy_force = 1'b1;
   bit          stall_prev = 1'b0;
   logic [31:0] hold_d;
   logic        hold_l;

   // Reference model state
   logic [15:0] m_amp = 16'd23170;
   bit          m_gray = 1'b1;
   bit          m_diff = 1'b0;
   logic [1:0]  m_acc = 2'd0;

   qpsk_symbol_mapper dut (
      .clk         (clk),
      .reset       (reset),
      .in_tdata    (in_tdata),
      .in_tlast    (in_tlast),
      .in_tvalid   (in_tvalid),
      .in_tready   (in_tready),
      .out_tdata   (out_tdata),
      .out_tlast   (out_tlast),
      .out_tvalid  (out_tvalid),
      .out_tready  (out_tready),
      .cfg_amp     (cfg_amp),
      .cfg_gray    (cfg_gray),
      .cfg_diff    (cfg_diff),
      .cfg_amp_stb (cfg_amp_stb),
      .phase_clear (phase_clear),
      .sym_count   (sym_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until it is accepted
   task automatic send(input logic [1:0] b, input logic last);
      int budget = 200;
      bit done = 1'b0;
      in_tdata  = {30'($urandom), b};
      in_tlast  = last;
      in_tvalid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_tready === 1'b1) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end else begin
            budget--;
            if (budget == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL send_timeout: in_tready stuck at %b, required 1", in_tready);
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic cfg(input logic [15:0] a, input bit g, input bit d);
      cfg_amp     = a;
      cfg_gray    = g;
      cfg_diff    = d;
      cfg_amp_stb = 1'b1;
      step();
      cfg_amp_stb = 1'b0;
      m_amp  = a[15] ? 16'h7FFF : a;
      m_gray = g;
      m_diff = d;
   endtask

   task automatic clear_pulse();
      phase_clear = 1'b1;
      step();
      phase_clear = 1'b0;
      m_acc = 2'd0;
   endtask

   function automatic logic [31:0] point(input logic [1:0] ph, input logic [15:0] a);
      logic [15:0] n;
      n = 16'(16'd0 - a);
      case (ph)
         2'd0:    point = {a, a};
         2'd1:    point = {n, a};
         2'd2:    point = {n, n};
         default: point = {a, n};
      endcase
   endfunction

   function automatic logic [32:0] model(input logic [1:0] b, input logic last);
      logic [1:0] p;
      logic [1:0] ph;
      if (m_gray) begin
         case (b)
            2'b00:   p = 2'd0;
            2'b01:   p = 2'd1;
            2'b11:   p = 2'd2;
            default: p = 2'd3;
         endcase
      end else begin
         p = b;
      end
      if (m_diff) begin
         m_acc = 2'(m_acc + p);
         ph = m_acc;
      end else begin
         ph = p;
      end
      model = {last, point(ph, m_amp)};
   endfunction

   // Wait for expected beats, then compare order, content and count
   task automatic drain(input string name);
      int budget = 5000;
      while (q_obs.size() < q_exp.size() && budget > 0) begin
         step();
         budget--;
      end
      repeat (4) step();
      n_vec++;
      if (q_obs.size() != q_exp.size()) begin
         n_err++;
         $display("FAIL %s_count: got %0d beats, required %0d", name, q_obs.size(), q_exp.size());
      end
      for (int i = 0; i < q_exp.size() && i < q_obs.size(); i++) begin
         n_vec++;
         if (q_obs[i] !== q_exp[i]) begin
            n_err++;
            $display("FAIL %s beat %0d: got last=%b data=%h, required last=%b data=%h",
                     name, i, q_obs[i][32], q_obs[i][31:0], q_exp[i][32], q_exp[i][31:0]);
         end
      end
      q_obs.delete();
      q_exp.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      n_vec++;
      if (out_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", out_tvalid); end
      n_vec++;
      if (out_tdata !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h, required 00000000", out_tdata); end
      n_vec++;
      if (out_tlast !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b, required 0", out_tlast); end
      n_vec++;
      if (sym_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d, required 0", sym_count); end
      reset = 1'b0;
      step();
      n_vec++;
      if (in_tready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, required 1", in_tready); end
   endtask

   task automatic test_gray();
      send(2'b00, 1'b0);
      n_vec++;
      if (out_tvalid !== 1'b0) begin n_err++; $display("FAIL gray_latency1: out_tvalid %b, required 0", out_tvalid); end
      send(2'b01, 1'b0);
      n_vec++;
      if (out_tvalid !== 1'b1 || out_tdata !== 32'h5A825A82) begin
         n_err++;
         $display("FAIL gray_latency2: valid=%b data=%h, required 1/5a825a82", out_tvalid, out_tdata);
      end
      send(2'b11, 1'b0);
      send(2'b10, 1'b1);
      in_tvalid = 1'b0;
      q_exp.push_back({1'b0, 32'h5A825A82});
      q_exp.push_back({1'b0, 32'hA57E5A82});
      q_exp.push_back({1'b0, 32'hA57EA57E});
      q_exp.push_back({1'b1, 32'h5A82A57E});
      drain("gray");
      n_vec++;
      if (sym_count !== 32'd4) begin n_err++; $display("FAIL gray_count: got %0d, required 4", sym_count); end
   endtask

   task automatic test_natural_diff();
      cfg(16'd23170, 1'b0, 1'b1);
      clear_pulse();
      send(2'b01, 1'b0);
      send(2'b01, 1'b0);
      send(2'b01, 1'b0);
      send(2'b01, 1'b0);
      send(2'b10, 1'b1);
      in_tvalid = 1'b0;
      q_exp.push_back({1'b0, 32'hA57E5A82});
      q_exp.push_back({1'b0, 32'hA57EA57E});
      q_exp.push_back({1'b0, 32'h5A82A57E});
      q_exp.push_back({1'b0, 32'h5A825A82});
      q_exp.push_back({1'b1, 32'hA57EA57E});
      drain("natdiff");
   endtask

   task automatic test_phase_clear();
      cfg(16'd23170, 1'b1, 1'b1);
      send(2'b01, 1'b0);
      phase_clear = 1'b1;
      send(2'b11, 1'b0);
      phase_clear = 1'b0;
      send(2'b01, 1'b0);
      in_tvalid = 1'b0;
      q_exp.push_back({1'b0, 32'h5A82A57E});
      q_exp.push_back({1'b0, 32'hA57EA57E});
      q_exp.push_back({1'b0, 32'h5A82A57E});
      drain("pclear");
   endtask

   task automatic test_amplitude();
      cfg(16'h8000, 1'b1, 1'b0);
      send(2'b00, 1'b0);
      send(2'b10, 1'b0);
      cfg_amp     = 16'h0000;
      cfg_amp_stb = 1'b1;
      send(2'b01, 1'b0);
      cfg_amp_stb = 1'b0;
      send(2'b11, 1'b1);
      in_tvalid = 1'b0;
      q_exp.push_back({1'b0, 32'h7FFF7FFF});
      q_exp.push_back({1'b0, 32'h7FFF8001});
      q_exp.push_back({1'b0, 32'h80017FFF});
      q_exp.push_back({1'b1, 32'h00000000});
      drain("amp");
   endtask

   task automatic test_backpressure();
      logic [1:0] b;
      logic       l;
      cfg(16'h1234, 1'b0, 1'b1);
      clear_pulse();
      bp_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            in_tvalid = 1'b0;
            step();
         end
         b = 2'($urandom);
         l = ($urandom_range(0, 7) == 0);
         send(b, l);
         q_exp.push_back(model(b, l));
      end
      in_tvalid = 1'b0;
      bp_en = 1'b0;
      drain("bp");
      n_vec++;
      if (sym_count !== 32'(n_xfer)) begin
         n_err++;
         $display("FAIL bp_count: got %0d, required %0d", sym_count, n_xfer);
      end
   endtask

   task automatic test_reset_mid();
      send(2'b00, 1'b0);
      send(2'b00, 1'b0);
      in_tvalid = 1'b0;
      n_vec++;
      if (out_tvalid !== 1'b1) begin n_err++; $display("FAIL mid_inflight: out_tvalid %b, required 1", out_tvalid); end
      reset = 1'b1;
      step();
      n_vec++;
      if (out_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b, required 0", out_tvalid); end
      n_vec++;
      if (sym_count !== 32'd0) begin n_err++; $display("FAIL mid_count: got %0d, required 0", sym_count); end
      q_obs.delete();
      q_exp.delete();
      reset = 1'b0;
      step();
      n_vec++;
      if (in_tready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b, required 1", in_tready); end
      send(2'b01, 1'b0);
      in_tvalid = 1'b0;
      cfg(16'd23170, 1'b1, 1'b1);
      send(2'b01, 1'b1);
      in_tvalid = 1'b0;
      q_exp.push_back({1'b0, 32'hA57E5A82});
      q_exp.push_back({1'b1, 32'hA57E5A82});
      drain("midrst");
   endtask

   initial begin
      fork
         // Output-ready driver: forced level or ~30% random duty
         forever begin
            @(posedge clk);
            #1;
            out_tready = bp_en ? ($urandom_range(0, 9) < 3) : rdy_force;
         end
         // Output monitor: capture transfers and check stall stability
         forever begin
            @(negedge clk);
            if (reset) begin
               stall_prev = 1'b0;
               n_xfer = 0;
            end else begin
               if (stall_prev) begin
                  n_vec++;
                  if (out_tvalid !== 1'b1 || out_tdata !== hold_d || out_tlast !== hold_l) begin
                     n_err++;
                     $display("FAIL stall_hold: valid=%b data=%h last=%b, required 1/%h/%b",
                              out_tvalid, out_tdata, out_tlast, hold_d, hold_l);
                  end
               end
               if (out_tvalid === 1'b1 && out_tready) begin
                  q_obs.push_back({out_tlast, out_tdata});
                  n_xfer++;
               end
               stall_prev = (out_tvalid === 1'b1) && !out_tready;
               hold_d = out_tdata;
               hold_l = out_tlast;
            end
         end
      join_none

      test_reset();
      test_gray();
      test_natural_diff();
      test_phase_clear();
      test_amplitude();
      test_backpressure();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
